// File: rtl/hazard_pkg.sv
// Shared types and constants for the in-order pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef struct packed {
    logic                  vld;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wren;
  } stage_entry_t;

endpackage

// File: rtl/hazard_cmp.sv
// Flags a read-after-write conflict between one ID source operand and the
// EX/MEM/WB shadow entries.
module hazard_cmp
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_addr,
  input  logic                  i_used,
  input  stage_entry_t          i_ex,
  input  stage_entry_t          i_mem,
  input  stage_entry_t          i_wb,
  output logic                  o_hit
);

  function automatic logic f_match(input stage_entry_t e, input logic [REG_ADDR_W-1:0] a);
    return e.vld && e.wren && (e.rd == a);
  endfunction

  // x0 is hardwired, so neither a read nor a write of it can conflict.
  assign o_hit = i_used && (i_addr != REG_X0) &&
                 (f_match(i_ex, i_addr) || f_match(i_mem, i_addr) || f_match(i_wb, i_addr));

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline without forwarding, with
// saturating stall and retire counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_id_vld,
  input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_id_rd_addr,
  input  logic                  i_id_rd_wren,
  input  logic                  i_ex_br_taken,
  input  logic                  i_mem_stall,
  output logic                  o_pc_en,
  output logic                  o_if_id_en,
  output logic                  o_if_id_flush,
  output logic                  o_id_ex_flush,
  output logic                  o_stall,
  output logic                  o_insn_vld,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_retire_cnt
);

  stage_entry_t     r_ex, r_mem, r_wb;
  stage_entry_t     w_id_entry;
  logic             w_rs1_hit, w_rs2_hit, w_raw, w_advance;
  logic [CNT_W-1:0] r_stall_cnt, r_retire_cnt;

  hazard_cmp u_cmp_rs1 (
    .i_addr (i_id_rs1_addr),
    .i_used (i_id_rs1_used),
    .i_ex   (r_ex),
    .i_mem  (r_mem),
    .i_wb   (r_wb),
    .o_hit  (w_rs1_hit)
  );

  hazard_cmp u_cmp_rs2 (
    .i_addr (i_id_rs2_addr),
    .i_used (i_id_rs2_used),
    .i_ex   (r_ex),
    .i_mem  (r_mem),
    .i_wb   (r_wb),
    .o_hit  (w_rs2_hit)
  );

  assign w_raw      = i_id_vld && (w_rs1_hit || w_rs2_hit);
  assign w_advance  = !i_mem_stall && !i_ex_br_taken && !w_raw;
  assign w_id_entry = '{vld: i_id_vld, rd: i_id_rd_addr, wren: i_id_rd_wren};

  always_comb begin
    o_pc_en       = 1'b1;
    o_if_id_en    = 1'b1;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_stall       = 1'b0;
    if (i_mem_stall) begin
      o_pc_en    = 1'b0;
      o_if_id_en = 1'b0;
      o_stall    = 1'b1;
    end else if (i_ex_br_taken) begin
      // ID holds a wrong-path instruction, so its hazard is irrelevant.
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (w_raw) begin
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_id_ex_flush = 1'b1;
      o_stall       = 1'b1;
    end
  end

  assign o_insn_vld = r_wb.vld && !i_mem_stall;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!i_mem_stall) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_advance ? w_id_entry : '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_cnt  <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (o_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (o_insn_vld && (r_retire_cnt != '1)) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stall_cnt  = r_stall_cnt;
  assign o_retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; counters narrowed to 4 bits so
// saturation is reachable.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  // Control vector: {pc_en, if_id_en, if_id_flush, id_ex_flush, stall, insn_vld}
  localparam logic [5:0] NORM = 6'b110000;
  localparam logic [5:0] BRCH = 6'b111100;
  localparam logic [5:0] RAWS = 6'b000110;
  localparam logic [5:0] MEMS = 6'b000010;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic             i_id_vld;
  logic [4:0]       i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr;
  logic             i_id_rs1_used, i_id_rs2_used, i_id_rd_wren;
  logic             i_ex_br_taken, i_mem_stall;
  logic             o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_stall, o_insn_vld;
  logic [CNT_W-1:0] o_stall_cnt, o_retire_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_id_vld      (i_id_vld),
    .i_id_rs1_addr (i_id_rs1_addr),
    .i_id_rs2_addr (i_id_rs2_addr),
    .i_id_rs1_used (i_id_rs1_used),
    .i_id_rs2_used (i_id_rs2_used),
    .i_id_rd_addr  (i_id_rd_addr),
    .i_id_rd_wren  (i_id_rd_wren),
    .i_ex_br_taken (i_ex_br_taken),
    .i_mem_stall   (i_mem_stall),
    .o_pc_en       (o_pc_en),
    .o_if_id_en    (o_if_id_en),
    .o_if_id_flush (o_if_id_flush),
    .o_id_ex_flush (o_id_ex_flush),
    .o_stall       (o_stall),
    .o_insn_vld    (o_insn_vld),
    .o_stall_cnt   (o_stall_cnt),
    .o_retire_cnt  (o_retire_cnt)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1: drive one ID slot, check controls at +3, return at next posedge+1.
  task automatic cyc(input string tag, input logic vld, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                     input logic wr, input logic br, input logic ms, input logic [5:0] exp);
    i_id_vld      = vld;
    i_id_rs1_addr = rs1;
    i_id_rs1_used = u1;
    i_id_rs2_addr = rs2;
    i_id_rs2_used = u2;
    i_id_rd_addr  = rd;
    i_id_rd_wren  = wr;
    i_ex_br_taken = br;
    i_mem_stall   = ms;
    #2;
    check_val(tag, {o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_stall, o_insn_vld}, exp);
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic [5:0] exp);
    cyc(tag, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp);
  endtask

  task automatic check_cnt(input string tag, input int stall_exp, input int retire_exp);
    check_val({tag, "_stall_cnt"}, 64'(o_stall_cnt), 64'(stall_exp));
    check_val({tag, "_retire_cnt"}, 64'(o_retire_cnt), 64'(retire_exp));
  endtask

  task automatic do_reset(input string tag);
    idle(tag, NORM);
    i_reset = 1'b1;
    #2;
    check_cnt({tag, "_rst"}, 0, 0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
  endtask

  initial begin
    i_reset       = 1'b1;
    i_id_vld      = 1'b0;
    i_id_rs1_addr = '0;
    i_id_rs2_addr = '0;
    i_id_rs1_used = 1'b0;
    i_id_rs2_used = 1'b0;
    i_id_rd_addr  = '0;
    i_id_rd_wren  = 1'b0;
    i_ex_br_taken = 1'b0;
    i_mem_stall   = 1'b0;
    @(posedge i_clk);
    #1;

    // Reset behaviour, including mem-stall override while in reset
    cyc("rst_norm", 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, NORM);
    cyc("rst_mem", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, MEMS);
    check_cnt("rst", 0, 0);
    i_reset = 1'b0;

    // Back-to-back dependency: three stall cycles
    cyc("b2b_prod", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, NORM);
    cyc("b2b_s1", 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, RAWS);
    cyc("b2b_s2", 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, RAWS);
    cyc("b2b_s3", 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, RAWS | 6'b1);
    cyc("b2b_iss", 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, NORM);
    check_cnt("b2b", 3, 1);

    // x0 destination and wren=0 never hazard
    do_reset("x0");
    cyc("x0_prod", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, NORM);
    cyc("x0_cons", 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, NORM);
    cyc("nowr_prod", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, NORM);
    cyc("nowr_cons", 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, NORM | 6'b1);
    idle("x0_d1", NORM | 6'b1);
    idle("x0_d2", NORM | 6'b1);
    idle("x0_d3", NORM | 6'b1);
    idle("x0_d4", NORM);
    check_cnt("x0", 0, 4);

    // Taken branch overrides a hazarding ID instruction
    do_reset("br");
    cyc("br_prod", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, NORM);
    cyc("br_flush", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, BRCH);
    cyc("br_gap1_s1", 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, RAWS);
    cyc("br_gap1_s2", 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, RAWS | 6'b1);
    cyc("br_gap1_iss", 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, NORM);
    check_cnt("br", 2, 1);

    // Mem stall freezes a RAW stall, which then resumes with its remaining count
    do_reset("ms");
    cyc("ms_prod", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, NORM);
    cyc("ms_raw1", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, RAWS);
    for (int i = 0; i < 5; i++) begin
      cyc("ms_frozen", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, MEMS);
    end
    check_cnt("ms_mid", 6, 0);
    cyc("ms_raw2", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, RAWS);
    cyc("ms_wb_held", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, MEMS);
    check_cnt("ms_wb_held", 8, 0);
    cyc("ms_raw3", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, RAWS | 6'b1);
    cyc("ms_iss", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, NORM);
    check_cnt("ms", 9, 1);

    // Independent stream, then retire counter saturation
    do_reset("ind");
    for (int i = 0; i < 13; i++) begin
      cyc("ind10", (i < 10), 5'd1, 1'b1, 5'd2, 1'b1, 5'(10 + i), 1'b1, 1'b0, 1'b0,
          NORM | {5'b0, (i >= 3)});
    end
    check_cnt("ind10", 0, 10);
    for (int i = 0; i < 11; i++) begin
      cyc("ind8", (i < 8), 5'd1, 1'b1, 5'd2, 1'b1, 5'(20 + i), 1'b1, 1'b0, 1'b0,
          NORM | {5'b0, (i >= 3)});
    end
    check_cnt("ind_sat", 0, 15);

    // Stall counter saturation
    do_reset("ssat");
    cyc("ssat_prod", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, NORM);
    for (int i = 0; i < 20; i++) begin
      cyc("ssat_ms", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, MEMS);
    end
    check_cnt("ssat", 15, 0);

    // Reset in the middle of a RAW stall drops the pending hazard
    do_reset("rms");
    cyc("rms_prod", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, NORM);
    cyc("rms_s1", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, RAWS);
    cyc("rms_s2", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, RAWS);
    check_cnt("rms_pre", 2, 0);
    i_reset = 1'b1;
    cyc("rms_in_rst", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, NORM);
    check_cnt("rms_rst", 0, 0);
    i_reset = 1'b0;
    cyc("rms_post", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, NORM);
    check_cnt("rms_post", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
